// File: rtl/mem_access_stage.sv
// Memory-stage load/store unit: turns pipeline loads/stores into req/gnt/rvalid bus transactions.
// Optional MEM_MISALIGN_TRAP_EN: misaligned halfword/word accesses raise MisalignM instead of a request.
module mem_access_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] RdataM,
    output logic        StallM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        MisalignM
`endif
);

    // state | meaning
    // IDLE  | request driven combinationally from pipeline inputs
    // REQ   | request held from registers until dmem_gnt
    // RESP  | load granted, waiting for dmem_rvalid
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

    state_t      state_q, state_d;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;

    logic        in_acc, in_we, is_byte, is_half, mis, issue, latch;
    logic [1:0]  off;
    logic [3:0]  in_be;
    logic [31:0] in_addr, in_wdata;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign off = ALUResultM[1:0];

    always_comb begin
        in_acc = MemReadM | MemWriteM;
        in_we  = MemWriteM;
        // Stores only honour their own codes; loads share width with their unsigned variants.
        if (MemWriteM) begin
            is_byte = (Funct3M == 3'b000);
            is_half = (Funct3M == 3'b001);
        end else begin
            is_byte = (Funct3M[1:0] == 2'b00);
            is_half = (Funct3M[1:0] == 2'b01);
        end
        in_addr = {ALUResultM[31:2], 2'b00};
        if (is_byte) begin
            in_be    = 4'b0001 << off;
            in_wdata = {4{WriteDataM[7:0]}};
        end else if (is_half) begin
            in_be    = 4'b0011 << {off[1], 1'b0};
            in_wdata = {2{WriteDataM[15:0]}};
        end else begin
            in_be    = 4'b1111;
            in_wdata = WriteDataM;
        end
`ifdef MEM_MISALIGN_TRAP_EN
        mis = in_acc & ((is_half & off[0]) | (~is_byte & ~is_half & (off != 2'b00)));
`else
        mis = 1'b0;
`endif
        issue = in_acc & ~mis;
    end

    always_comb begin
        case (off_q)
            2'd0:    byte_sel = dmem_rdata[7:0];
            2'd1:    byte_sel = dmem_rdata[15:8];
            2'd2:    byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'b0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'b0, half_sel};
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        latch      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = we_q;
        dmem_addr  = addr_q;
        dmem_be    = be_q;
        dmem_wdata = wdata_q;
        StallM     = 1'b0;
        RdataM     = '0;
        case (state_q)
            IDLE: begin
                dmem_req   = issue;
                dmem_we    = in_we;
                dmem_addr  = in_addr;
                dmem_be    = in_be;
                dmem_wdata = in_wdata;
                if (issue) begin
                    if (dmem_gnt) begin
                        StallM = ~in_we;
                        if (!in_we) begin
                            state_d = RESP;
                            latch   = 1'b1;
                        end
                    end else begin
                        StallM  = 1'b1;
                        state_d = REQ;
                        latch   = 1'b1;
                    end
                end
            end
            REQ: begin
                dmem_req = 1'b1;
                StallM   = ~(dmem_gnt & we_q);
                if (dmem_gnt) state_d = we_q ? IDLE : RESP;
            end
            RESP: begin
                StallM = ~dmem_rvalid;
                if (dmem_rvalid) begin
                    state_d = IDLE;
                    RdataM  = load_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign MisalignM = (state_q == IDLE) & mis;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            off_q    <= '0;
            funct3_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                we_q     <= in_we;
                addr_q   <= in_addr;
                be_q     <= in_be;
                wdata_q  <= in_wdata;
                off_q    <= off;
                funct3_q <= Funct3M;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: driver acts as pipeline and bus agent, monitor checks bus and load data.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] RdataM;
    logic        StallM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        MisalignM;
`endif

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk(clk), .rst_n(rst_n),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .RdataM(RdataM), .StallM(StallM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
`ifdef MEM_MISALIGN_TRAP_EN
        , .MisalignM(MisalignM)
`endif
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    req_t        req_q[$];
    logic [31:0] rd_q[$];
    req_t        mon_e;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          ignore_rv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic bit w_byte(input bit wr, input logic [2:0] f3);
        return wr ? (f3 == 3'd0) : (f3 == 3'd0 || f3 == 3'd4);
    endfunction

    function automatic bit w_half(input bit wr, input logic [2:0] f3);
        return wr ? (f3 == 3'd1) : (f3 == 3'd1 || f3 == 3'd5);
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int unsigned off;
        logic [31:0] v;
        off = a % 4;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            v = (d >> (8 * off)) & 32'hFF;
            if (f3 == 3'd0 && v >= 128) v = v - 32'd256;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            v = (d >> (16 * (off / 2))) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32768) v = v - 32'd65536;
        end else begin
            v = d;
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (dmem_req) begin
                if (req_q.size() == 0) begin
                    check("req_unexpected", 32'(dmem_req), 32'd0);
                end else begin
                    mon_e = req_q[0];
                    check("dmem_we", 32'(dmem_we), 32'(mon_e.we));
                    check("dmem_addr", dmem_addr, mon_e.addr);
                    check("dmem_be", 32'(dmem_be), 32'(mon_e.be));
                    if (mon_e.we) check("dmem_wdata", dmem_wdata, mon_e.wdata);
                    if (dmem_gnt) void'(req_q.pop_front());
                end
            end
            if (dmem_rvalid && !ignore_rv) begin
                if (rd_q.size() == 0) check("rvalid_unexpected", 32'(dmem_rvalid), 32'd0);
                else check("RdataM", RdataM, rd_q.pop_front());
            end else begin
                check("RdataM_zero", RdataM, 32'd0);
            end
        end
    end

    task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int gdly, input int rdly, input logic [31:0] rdata);
        bit   is_b, is_h, mis;
        int   done;
        req_t e;
        is_b = w_byte(wr, f3);
        is_h = w_half(wr, f3);
        mis  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        mis = (is_h && a[0]) || (!is_b && !is_h && (a % 4) != 0);
`endif
        if (!mis) begin
            e.we   = wr;
            e.addr = a - (a % 4);
            if (is_b) begin
                e.be    = 4'(1 << (a % 4));
                e.wdata = {24'b0, wd[7:0]} * 32'h01010101;
            end else if (is_h) begin
                e.be    = 4'(3 << (a & 32'd2));
                e.wdata = {16'b0, wd[15:0]} * 32'h00010001;
            end else begin
                e.be    = 4'hF;
                e.wdata = wd;
            end
            req_q.push_back(e);
            if (!wr) rd_q.push_back(exp_load(f3, a, rdata));
        end
        done = mis ? 0 : (wr ? gdly : gdly + rdly);
        MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = a; WriteDataM = wd;
        for (int c = 0; c <= done; c++) begin
            // While a request is parked in REQ the unit must ignore the pipeline operands.
            if (c > 0 && c <= gdly) begin
                Funct3M = 3'($urandom); ALUResultM = $urandom; WriteDataM = $urandom;
            end
            dmem_gnt    = !mis && (c == gdly);
            dmem_rvalid = !mis && !wr && (c == gdly + rdly);
            dmem_rdata  = dmem_rvalid ? rdata : $urandom;
            @(negedge clk);
            check("StallM", 32'(StallM), 32'(c != done));
`ifdef MEM_MISALIGN_TRAP_EN
            if (c == 0) check("MisalignM", 32'(MisalignM), 32'(mis));
`endif
            @(posedge clk); #1;
        end
        MemReadM = 1'b0; MemWriteM = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            MemReadM = 1'b0; MemWriteM = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            @(negedge clk);
            check("idle_StallM", 32'(StallM), 32'd0);
            check("idle_req", 32'(dmem_req), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bit          rd, wr;
        logic [2:0]  f3;
        logic [2:0]  codes[5];
        codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        rst_n = 1'b0;
        MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'd0; ALUResultM = '0; WriteDataM = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_req", 32'(dmem_req), 32'd0);
        check("reset_StallM", 32'(StallM), 32'd0);
        check("reset_RdataM", RdataM, 32'd0);
        @(posedge clk); #1;

        run_txn(0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 1, 32'd0);
        run_txn(0, 1, 3'd0, 32'h203, 32'h123456A5, 3, 1, 32'd0);
        run_txn(1, 0, 3'd0, 32'h002, 32'd0, 0, 2, 32'h0080_0000);
        run_txn(1, 0, 3'd4, 32'h002, 32'd0, 1, 2, 32'h0080_0000);
        run_txn(1, 0, 3'd1, 32'h006, 32'd0, 0, 1, 32'h8001_0000);
        run_txn(1, 0, 3'd5, 32'h006, 32'd0, 2, 1, 32'h8001_0000);
        run_txn(1, 0, 3'd2, 32'h101, 32'd0, 0, 1, 32'hCAFE_F00D);
        run_txn(1, 1, 3'd1, 32'h032, 32'h0000_BEEF, 1, 1, 32'd0);
        idle(1);

        // Reset while a load waits in RESP; a late rvalid afterwards must be ignored.
        e_push_reset_load();
        run_txn(1, 0, 3'd0, 32'h041, 32'd0, 0, 1, 32'h0000_FF00);

        for (int t = 0; t < 200; t++) begin
            wr = 1'($urandom_range(0, 1));
            rd = !wr || ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
            else f3 = codes[$urandom_range(0, 4)];
            run_txn(rd, wr, f3, $urandom, $urandom, int'($urandom_range(0, 3)),
                    int'($urandom_range(1, 3)), $urandom);
            idle(int'($urandom_range(0, 2)));
        end

        check("req_q_drained", 32'(req_q.size()), 32'd0);
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    task automatic e_push_reset_load();
        req_t e;
        e.we = 1'b0; e.addr = 32'h40; e.be = 4'hF; e.wdata = '0;
        req_q.push_back(e);
        MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'd2; ALUResultM = 32'h40; WriteDataM = '0;
        dmem_gnt = 1'b1;
        @(negedge clk);
        check("rst_load_StallM", 32'(StallM), 32'd1);
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        rst_n = 1'b0;
        MemReadM = 1'b0;
        ignore_rv = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("rst_late_RdataM", RdataM, 32'd0);
        check("rst_late_StallM", 32'(StallM), 32'd0);
        check("rst_late_req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        ignore_rv = 1'b0;
    endtask

endmodule
